// File: rtl/register_16b.sv
// Load-enabled data register with asynchronous active-low reset.
// Define REGISTER_PARITY_EN to add a registered even-parity output Q_par.
module register_16b #(
    parameter int unsigned     WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
`ifdef REGISTER_PARITY_EN
    output logic             Q_par,
`endif
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VALUE;
        end else if (en) begin
            r_q <= D;
        end
    end

    assign Q = r_q;

`ifdef REGISTER_PARITY_EN
    logic r_par;
    logic w_d_par;

    // Parity is taken from D so it lands on the same edge as Q.
    assign w_d_par = ^D;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= ^RESET_VALUE;
        end else if (en) begin
            r_par <= w_d_par;
        end
    end

    assign Q_par = r_par;
`endif

endmodule

// File: tb/tb_register_16b.sv
// Self-checking bench for register_16b using an expected-value queue.
// Parity checks are compiled in when REGISTER_PARITY_EN is defined.
module tb_register_16b;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] D;
    logic [15:0] Q;
`ifdef REGISTER_PARITY_EN
    logic        Q_par;
`endif

    int n_checks;
    int n_fail;

    logic [15:0] m_q;
    logic [15:0] sb[$];
    logic [15:0] exp_q;

    register_16b #(
        .WIDTH      (16),
        .RESET_VALUE(16'h0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .D    (D),
`ifdef REGISTER_PARITY_EN
        .Q_par(Q_par),
`endif
        .Q    (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs and push the value Q must show after the next edge.
    task automatic drive(input logic e, input logic [15:0] d);
        en = e;
        D  = d;
        if (e) m_q = d;
        sb.push_back(m_q);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        D     = 16'h0000;
        m_q   = 16'h0000;
        sb.delete();
        #1;
        n_checks++;
        if (Q !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_initial: Q=%h expected=%h", Q, 16'h0000);
        end
`ifdef REGISTER_PARITY_EN
        n_checks++;
        if (Q_par !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_par: Q_par=%b expected=0", Q_par);
        end
`endif
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b1, 16'h1234);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++;
            $display("FAIL reset_preload: Q=%h expected=%h", Q, exp_q);
        end
        // Mid-cycle pulse: Q must clear before the next edge arrives.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (Q !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_async: Q=%h expected=%h", Q, 16'h0000);
        end
        tick();
        n_checks++;
        if (Q !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_held: Q=%h expected=%h", Q, 16'h0000);
        end
        en    = 1'b0;
        D     = 16'h0000;
        m_q   = 16'h0000;
        rst_n = 1'b1;
    endtask

    task automatic test_hold();
        drive(1'b0, 16'h0000);
        drive(1'b0, 16'h0013);
        drive(1'b0, 16'h0013);
        drive(1'b0, 16'h0031);
        sb.delete();
        m_q = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] d_val;
            d_val = (i == 0) ? 16'h0000 : (i < 3) ? 16'h0013 : 16'h0031;
            drive(1'b0, d_val);
            tick();
            exp_q = sb.pop_front();
            n_checks++;
            if (Q !== exp_q) begin
                n_fail++;
                $display("FAIL hold_%0d: Q=%h expected=%h", i, Q, exp_q);
            end
        end
    endtask

    task automatic test_load();
        drive(1'b1, 16'h0031);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++;
            $display("FAIL load_first: Q=%h expected=%h", Q, exp_q);
        end
        drive(1'b1, 16'h0031);
        tick();
        void'(sb.pop_front());
        drive(1'b0, 16'h0031);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++;
            $display("FAIL load_disable: Q=%h expected=%h", Q, exp_q);
        end
        drive(1'b0, 16'h5555);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++;
            $display("FAIL load_ignore_d: Q=%h expected=%h", Q, exp_q);
        end
    endtask

    task automatic test_reenable();
        drive(1'b1, 16'h0031);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++;
            $display("FAIL reenable_same: Q=%h expected=%h", Q, exp_q);
        end
        drive(1'b1, 16'h0001);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++;
            $display("FAIL reenable_track: Q=%h expected=%h", Q, exp_q);
        end
    endtask

    task automatic test_glitch();
        en = 1'b1;
        D  = 16'hFFFF;
        #2;
        drive(1'b1, 16'h00AA);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++;
            $display("FAIL glitch_d: Q=%h expected=%h", Q, exp_q);
        end
        // en pulses high between edges but is low at the edge.
        en = 1'b0;
        D  = 16'h1111;
        #1;
        en = 1'b1;
        D  = 16'h2222;
        #1;
        drive(1'b0, 16'h1111);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++;
            $display("FAIL glitch_en: Q=%h expected=%h", Q, exp_q);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'($urandom_range(0, 16'hFFFF)));
            tick();
            exp_q = sb.pop_front();
            n_checks++;
            if (Q !== exp_q) begin
                n_fail++;
                $display("FAIL b2b_%0d: Q=%h expected=%h", i, Q, exp_q);
            end
        end
    endtask

    task automatic test_reset_vs_load();
        en = 1'b1;
        D  = 16'hBEEF;
        #2;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (Q !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_vs_load: Q=%h expected=%h", Q, 16'h0000);
        end
        en    = 1'b0;
        m_q   = 16'h0000;
        sb.delete();
        rst_n = 1'b1;
        drive(1'b0, 16'hBEEF);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++;
            $display("FAIL reset_vs_load_after: Q=%h expected=%h", Q, exp_q);
        end
    endtask

`ifdef REGISTER_PARITY_EN
    task automatic test_parity();
        logic [15:0] vals[4];
        vals = '{16'h0007, 16'h0003, 16'h8001, 16'h7FFF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i]);
            tick();
            exp_q = sb.pop_front();
            n_checks++;
            if (Q !== exp_q) begin
                n_fail++;
                $display("FAIL parity_q_%0d: Q=%h expected=%h", i, Q, exp_q);
            end
            n_checks++;
            if (Q_par !== ^exp_q) begin
                n_fail++;
                $display("FAIL parity_bit_%0d: Q_par=%b expected=%b", i, Q_par, ^exp_q);
            end
        end
        // Parity holds along with Q when disabled.
        drive(1'b0, 16'h0001);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q_par !== ^exp_q) begin
            n_fail++;
            $display("FAIL parity_hold: Q_par=%b expected=%b", Q_par, ^exp_q);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_hold();
        test_load();
        test_reenable();
        test_glitch();
        test_back_to_back();
        test_reset_vs_load();
`ifdef REGISTER_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_16b.md
Name: register_16b

Overview:
- General-purpose load-enabled data register: the basic storage element of the 16-bit processor datapath, used for the register file, accumulator and pipeline holding registers.
- Captures the data input on the rising clock edge when `en` is high; holds its value otherwise.
- Asynchronous active-low reset forces a known value.

Parameters:
- WIDTH, 16, data width in bits of `D` and `Q`; legal range 1 to 64.
- RESET_VALUE, 16'h0000 (WIDTH bits, all zero), value loaded into `Q` on reset.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  load enable; sampled on the rising edge of `clk`.
- D  input  WIDTH  data to load.
- Q  output  WIDTH  stored value, driven directly from flops; no combinational path from `D` or `en`.
- Q_par  output  1  present only with REGISTER_PARITY_EN; see Optional Feature.

Behaviour:
- Reset:
  - `rst_n` low forces `Q` = RESET_VALUE immediately, independent of `clk`.
  - `Q` holds RESET_VALUE while `rst_n` is low.
  - Deassertion is sampled by `clk`. The first load can occur on the first rising edge at which `rst_n` is already high.
- Load:
  - On a rising edge of `clk` with `rst_n` high and `en` = 1: `Q` <= `D`.
  - New value is visible after the edge; latency is 1 clock from sampled `D` to `Q`.
- Hold:
  - On a rising edge with `en` = 0: `Q` keeps its previous value.
  - `D` changes have no effect while `en` = 0.
- Only values present at the rising edge matter. `D` or `en` changes between edges never alter `Q`.
- Back-to-back loads: with `en` held at 1, `Q` tracks `D` with a one-cycle delay on every edge.
- Simultaneous events: reset dominates. If `rst_n` is low at a clock edge, `Q` = RESET_VALUE regardless of `en` or `D`.
- Reset mid-operation: asserting `rst_n` at any time discards the stored value. There is no retained state.
- Unknown inputs: if `en` is X at an edge, `Q` may become X. The bench keeps `en` known after reset.
- Width rules: `D` and `Q` are exactly WIDTH bits. No extension or truncation happens inside the block.
- No handshake: single-cycle, always ready. There is no state machine.

Optional Feature:
- Macro: REGISTER_PARITY_EN.
- When defined:
  - Output `Q_par` exists and holds the even-parity bit (XOR reduction) of the stored value.
  - `Q_par` is computed from `D` and registered together with `Q` under the same `en`.
  - Reset value of `Q_par` is the XOR of RESET_VALUE (0 for the default).
  - `Q_par` updates on exactly the same edge as `Q`.
- When undefined:
  - `Q_par` port and its flop are absent.
  - Behaviour of `Q` is identical in both builds.

Test Plan:
- Reset: drive `D`=16'h1234, `en`=1, pulse `rst_n` low mid-cycle -> `Q`=16'h0000 immediately (before the next edge), and stays 0 while `rst_n` is low.
- Hold while disabled: after reset, `rst_n`=1, `en`=0; `D` goes 16'h0000 then 16'h0013, then 16'h0031 two cycles later -> `Q` stays 16'h0000 throughout.
- Load:
  - Raise `en`=1 with `D`=16'h0031 -> `Q`=16'h0031 after the next rising edge.
  - Two cycles later drop `en`=0 -> `Q` stays 16'h0031.
- Re-enable and track:
  - `en`=1 again with `D`=16'h0031 -> `Q` remains 16'h0031.
  - Change `D` to 16'h0001 -> `Q`=16'h0001 exactly one edge later.
- Mid-cycle glitch: with `en`=1, change `D` to 16'hFFFF and back to 16'h00AA between edges -> `Q` takes only 16'h00AA at the edge. Toggling `en` between edges has no effect.
- Reset versus load at the same edge: `rst_n` low with `en`=1, `D`=16'hBEEF at the edge -> `Q`=16'h0000. With REGISTER_PARITY_EN defined, load 16'h0007 -> `Q_par`=1; load 16'h0003 -> `Q_par`=0.
